// File: rtl/regfile_alu_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_alu_datapath
//  Purpose  : Execution datapath for the Fibonacci sequencer. Sixteen
//             general registers, A/B operand select muxes with an immediate
//             substitute on B, a single-cycle ALU, a registered result bus
//             and a five-bit status (flags) register.
//  Ports    :
//    clk          in   system clock, all state changes on the rising edge
//    reset        in   synchronous active-high reset
//    immediate    in   immediate operand (replaces B when imm_control=1)
//    enable       in   per-register write enable, bit n writes rn
//    control1     in   A select: 1..NREGS -> r(code-1), anything else -> 0
//    control2     in   B select, same coding as control1
//    imm_control  in   1 selects immediate as the B operand
//    opcode       in   ALU operation
//    buff_en      in   gates register writeback and the result bus
//    bus_out      out  registered result of the last bus-updating op
//    bus_valid    out  high for the cycle after bus_out was updated
//    flags        out  {C, L, F, Z, N}
//    dbg_sel      in   debug register select
//    dbg_data     out  combinational contents of r[dbg_sel]
//  Revision : 1.0  initial release
// ============================================================================
module regfile_alu_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] immediate,
  input  logic [NREGS-1:0] enable,
  input  logic [4:0]       control1,
  input  logic [4:0]       control2,
  input  logic             imm_control,
  input  logic [7:0]       opcode,
  input  logic             buff_en,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  output logic [4:0]       flags,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  // Opcode map
  localparam logic [7:0] c_OP_NOP  = 8'h00;
  localparam logic [7:0] c_OP_AND  = 8'h01;
  localparam logic [7:0] c_OP_OR   = 8'h02;
  localparam logic [7:0] c_OP_XOR  = 8'h03;
  localparam logic [7:0] c_OP_NOT  = 8'h04;
  localparam logic [7:0] c_OP_ADD  = 8'h05;
  localparam logic [7:0] c_OP_ADDC = 8'h06;
  localparam logic [7:0] c_OP_SUB  = 8'h07;
  localparam logic [7:0] c_OP_CMP  = 8'h08;
  localparam logic [7:0] c_OP_LSH  = 8'h09;
  localparam logic [7:0] c_OP_RSH  = 8'h0A;
  localparam logic [7:0] c_OP_MOV  = 8'h0B;

  // Bit positions inside the flags register
  localparam int c_FC = 4;
  localparam int c_FL = 3;
  localparam int c_FF = 2;
  localparam int c_FZ = 1;
  localparam int c_FN = 0;

  localparam int c_SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_bus;
  logic             r_bus_valid;
  logic [4:0]       r_flags;

  logic [WIDTH-1:0] w_reg_a;
  logic [WIDTH-1:0] w_reg_b;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH:0]   w_sum;
  logic             w_is_exec;
  logic             w_is_cmp;
  logic             w_upd_cf;
  logic             w_upd_l;
  logic             w_c_new;
  logic             w_f_new;
  logic             w_ult;
  logic             w_slt;
  logic             w_commit;

  // --------------------------------------------------------------------------
  // Operand selection. Code 0 and codes beyond the register count read as
  // zero, which lets the sequencer build "r0 + imm" style ops or a pure
  // immediate without needing a dedicated zero register.
  // --------------------------------------------------------------------------
  always_comb begin
    w_reg_a = '0;
    w_reg_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (control1 == 5'(i + 1)) w_reg_a = r_regs[i];
      if (control2 == 5'(i + 1)) w_reg_b = r_regs[i];
    end
  end

  assign w_a = w_reg_a;
  assign w_b = imm_control ? immediate : w_reg_b;

  // Comparison terms shared by SUB and CMP
  assign w_ult = (w_a < w_b);
  assign w_slt = ($signed(w_a) < $signed(w_b));

  // --------------------------------------------------------------------------
  // ALU. Arithmetic is done one bit wider so the carry / borrow falls out of
  // the top bit; the stored result is the low WIDTH bits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_result  = '0;
    w_sum     = '0;
    w_is_exec = 1'b0;
    w_is_cmp  = 1'b0;
    w_upd_cf  = 1'b0;
    w_upd_l   = 1'b0;
    w_c_new   = r_flags[c_FC];
    w_f_new   = r_flags[c_FF];
    case (opcode)
      c_OP_AND: begin
        w_result  = w_a & w_b;
        w_is_exec = 1'b1;
      end
      c_OP_OR: begin
        w_result  = w_a | w_b;
        w_is_exec = 1'b1;
      end
      c_OP_XOR: begin
        w_result  = w_a ^ w_b;
        w_is_exec = 1'b1;
      end
      c_OP_NOT: begin
        w_result  = ~w_a;
        w_is_exec = 1'b1;
      end
      c_OP_ADD, c_OP_ADDC: begin
        if (opcode == c_OP_ADDC)
          w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, r_flags[c_FC]};
        else
          w_sum = {1'b0, w_a} + {1'b0, w_b};
        w_result  = w_sum[WIDTH-1:0];
        w_c_new   = w_sum[WIDTH];
        // Overflow: both operands share a sign that the result does not
        w_f_new   = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                    (w_result[WIDTH-1] != w_a[WIDTH-1]);
        w_upd_cf  = 1'b1;
        w_is_exec = 1'b1;
      end
      c_OP_SUB: begin
        w_sum     = {1'b0, w_a} - {1'b0, w_b};
        w_result  = w_sum[WIDTH-1:0];
        // The wrapped top bit of the widened difference is the borrow
        w_c_new   = w_sum[WIDTH];
        // Overflow: operand signs differ and the result takes B's sign
        w_f_new   = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                    (w_result[WIDTH-1] != w_a[WIDTH-1]);
        w_upd_cf  = 1'b1;
        w_upd_l   = 1'b1;
        w_is_exec = 1'b1;
      end
      c_OP_CMP: begin
        w_is_cmp = 1'b1;
      end
      c_OP_LSH: begin
        w_result  = w_a << w_b[c_SHW-1:0];
        w_is_exec = 1'b1;
      end
      c_OP_RSH: begin
        w_result  = w_a >> w_b[c_SHW-1:0];
        w_is_exec = 1'b1;
      end
      c_OP_MOV: begin
        w_result  = w_b;
        w_is_exec = 1'b1;
      end
      default: begin
        // c_OP_NOP and every undefined code: nothing changes
      end
    endcase
  end

  // Writeback and bus update only happen for result-producing ops with the
  // bus enabled; flags are independent of buff_en.
  assign w_commit = buff_en && w_is_exec;

  // --------------------------------------------------------------------------
  // Register file. Each register has its own enable so several can be
  // loaded from one result in the same cycle.
  // --------------------------------------------------------------------------
  for (genvar n = 0; n < NREGS; n++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset)
        r_regs[n] <= '0;
      else if (w_commit && enable[n])
        r_regs[n] <= w_result;
    end
  end

  // Result bus
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus       <= '0;
      r_bus_valid <= 1'b0;
    end else begin
      r_bus_valid <= w_commit;
      if (w_commit)
        r_bus <= w_result;
    end
  end

  // Status register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else if (w_is_exec) begin
      r_flags[c_FZ] <= (w_result == '0);
      r_flags[c_FN] <= w_result[WIDTH-1];
      if (w_upd_cf) begin
        r_flags[c_FC] <= w_c_new;
        r_flags[c_FF] <= w_f_new;
      end
      if (w_upd_l)
        r_flags[c_FL] <= w_ult;
    end else if (w_is_cmp) begin
      r_flags[c_FZ] <= (w_a == w_b);
      r_flags[c_FN] <= w_slt;
      r_flags[c_FL] <= w_ult;
    end
  end

  assign bus_out   = r_bus;
  assign bus_valid = r_bus_valid;
  assign flags     = r_flags;
  assign dbg_data  = r_regs[dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_alu_datapath
//  Purpose  : Self-checking bench for regfile_alu_datapath. Controls change
//             on the falling edge like the sequencer; results are sampled
//             1 ns after the rising edge. Expected bus values are queued as
//             stimulus is driven and popped when bus_valid is observed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_alu_datapath;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h05;
  localparam logic [7:0] OP_SUB = 8'h07;
  localparam logic [7:0] OP_CMP = 8'h08;
  localparam logic [7:0] OP_MOV = 8'h0B;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] immediate = '0;
  logic [15:0] enable = '0;
  logic [4:0]  control1 = '0;
  logic [4:0]  control2 = '0;
  logic        imm_control = 1'b0;
  logic [7:0]  opcode = '0;
  logic        buff_en = 1'b0;
  logic [15:0] bus_out;
  logic        bus_valid;
  logic [4:0]  flags;
  logic [3:0]  dbg_sel = '0;
  logic [15:0] dbg_data;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];

  regfile_alu_datapath #(.WIDTH(16), .NREGS(16)) dut (
    .clk(clk), .reset(reset), .immediate(immediate), .enable(enable),
    .control1(control1), .control2(control2), .imm_control(imm_control),
    .opcode(opcode), .buff_en(buff_en), .bus_out(bus_out),
    .bus_valid(bus_valid), .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Apply one control bundle on the falling edge, return 1 ns after the
  // rising edge that consumes it.
  task automatic drive(input logic rst_v, input logic [15:0] imm, input logic [15:0] en,
                       input logic [4:0] c1, input logic [4:0] c2, input logic ic,
                       input logic [7:0] op, input logic be);
    @(negedge clk);
    reset = rst_v; immediate = imm; enable = en; control1 = c1; control2 = c2;
    imm_control = ic; opcode = op; buff_en = be;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [3:0] s, output logic [15:0] v);
    dbg_sel = s;
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    drive(1'b1, 16'd5, 16'hFFFF, 5'd1, 5'd0, 1'b1, OP_ADD, 1'b1);
    drive(1'b1, 16'd5, 16'hFFFF, 5'd1, 5'd0, 1'b1, OP_ADD, 1'b1);
    checks++;
    if (bus_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
    checks++;
    if (bus_out !== 16'h0000) begin failures++; $display("FAIL reset_bus: got %h want 0000", bus_out); end
    checks++;
    if (flags !== 5'b00000) begin failures++; $display("FAIL reset_flags: got %b want 00000", flags); end
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), v);
      checks++;
      if (v !== 16'h0000) begin failures++; $display("FAIL reset_r%0d: got %h want 0000", i, v); end
    end
  endtask

  task automatic test_fibonacci();
    logic [15:0] fen [6] = '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0020};
    logic [4:0]  fc1 [6] = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4};
    logic [4:0]  fc2 [6] = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd5, 5'd5};
    logic        fic [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0]  fdst[6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5};
    logic [15:0] fexp[6] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd5};
    logic [15:0] v, e;
    for (int s = 0; s < 6; s++) begin
      sb.push_back(fexp[s]);
      drive(1'b0, 16'd1, fen[s], fc1[s], fc2[s], fic[s], OP_ADD, 1'b1);
      checks++;
      if (bus_valid !== 1'b1) begin failures++; $display("FAIL fib_valid step%0d: got %b want 1", s + 1, bus_valid); end
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL fib_scoreboard step%0d: got empty queue want entry", s + 1);
      end else begin
        e = sb.pop_front();
        if (bus_out !== e) begin failures++; $display("FAIL fib_bus step%0d: got %h want %h", s + 1, bus_out, e); end
      end
      peek(fdst[s], v);
      checks++;
      if (v !== fexp[s]) begin failures++; $display("FAIL fib_reg step%0d r%0d: got %h want %h", s + 1, fdst[s], v, fexp[s]); end
    end
    checks++;
    if (flags !== 5'b00000) begin failures++; $display("FAIL fib_flags: got %b want 00000", flags); end
  endtask

  task automatic test_arith_edges();
    logic [15:0] e;
    // r6 = 0x7FFF, then r6 + 1
    sb.push_back(16'h7FFF);
    drive(1'b0, 16'h7FFF, 16'h0040, 5'd0, 5'd0, 1'b1, OP_MOV, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus_out !== e) begin failures++; $display("FAIL mov_7fff_bus: got %h want %h", bus_out, e); end
    sb.push_back(16'h8000);
    drive(1'b0, 16'd1, 16'h0000, 5'd7, 5'd0, 1'b1, OP_ADD, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus_out !== e || bus_valid !== 1'b1) begin failures++; $display("FAIL add_ovf_bus: got %h/%b want %h/1", bus_out, bus_valid, e); end
    checks++;
    if (flags !== 5'b00101) begin failures++; $display("FAIL add_ovf_flags: got %b want 00101", flags); end
    // r6 = 0xFFFF, then r6 + 1 wraps to zero with carry
    sb.push_back(16'hFFFF);
    drive(1'b0, 16'hFFFF, 16'h0040, 5'd0, 5'd0, 1'b1, OP_MOV, 1'b1);
    void'(sb.pop_front());
    sb.push_back(16'h0000);
    drive(1'b0, 16'd1, 16'h0000, 5'd7, 5'd0, 1'b1, OP_ADD, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus_out !== e) begin failures++; $display("FAIL add_carry_bus: got %h want %h", bus_out, e); end
    checks++;
    if (flags !== 5'b10010) begin failures++; $display("FAIL add_carry_flags: got %b want 10010", flags); end
    // r7 = 3, then 3 - 5
    sb.push_back(16'h0003);
    drive(1'b0, 16'd3, 16'h0080, 5'd0, 5'd0, 1'b1, OP_MOV, 1'b1);
    void'(sb.pop_front());
    sb.push_back(16'hFFFE);
    drive(1'b0, 16'd5, 16'h0000, 5'd8, 5'd0, 1'b1, OP_SUB, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus_out !== e) begin failures++; $display("FAIL sub_bus: got %h want %h", bus_out, e); end
    checks++;
    if (flags !== 5'b11001) begin failures++; $display("FAIL sub_flags: got %b want 11001", flags); end
  endtask

  task automatic test_gating();
    logic [15:0] v, e;
    // buff_en low: flags move, nothing else does (r1 = 1 from Fibonacci)
    drive(1'b0, 16'h7FFF, 16'h0002, 5'd2, 5'd0, 1'b1, OP_ADD, 1'b0);
    checks++;
    if (bus_valid !== 1'b0 || bus_out !== 16'hFFFE) begin failures++; $display("FAIL gate_bus: got %h/%b want fffe/0", bus_out, bus_valid); end
    checks++;
    if (flags !== 5'b01101) begin failures++; $display("FAIL gate_flags: got %b want 01101", flags); end
    peek(4'd1, v);
    checks++;
    if (v !== 16'h0001) begin failures++; $display("FAIL gate_r1: got %h want 0001", v); end
    // r1 = 5, then CMP r1 vs 5
    sb.push_back(16'h0005);
    drive(1'b0, 16'd5, 16'h0002, 5'd0, 5'd0, 1'b1, OP_MOV, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus_out !== e) begin failures++; $display("FAIL mov5_bus: got %h want %h", bus_out, e); end
    drive(1'b0, 16'd5, 16'h0002, 5'd2, 5'd0, 1'b1, OP_CMP, 1'b1);
    checks++;
    if (flags !== 5'b00110) begin failures++; $display("FAIL cmp_flags: got %b want 00110", flags); end
    checks++;
    if (bus_valid !== 1'b0 || bus_out !== 16'h0005) begin failures++; $display("FAIL cmp_bus: got %h/%b want 0005/0", bus_out, bus_valid); end
    peek(4'd1, v);
    checks++;
    if (v !== 16'h0005) begin failures++; $display("FAIL cmp_r1: got %h want 0005", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v, e;
    logic [4:0]  fl;
    sb.push_back(16'h00AA);
    drive(1'b0, 16'h00AA, 16'h0006, 5'd0, 5'd0, 1'b1, OP_MOV, 1'b1);
    e = sb.pop_front();
    checks++;
    if (bus_out !== e) begin failures++; $display("FAIL multi_bus: got %h want %h", bus_out, e); end
    peek(4'd1, v);
    checks++;
    if (v !== 16'h00AA) begin failures++; $display("FAIL multi_r1: got %h want 00aa", v); end
    peek(4'd2, v);
    checks++;
    if (v !== 16'h00AA) begin failures++; $display("FAIL multi_r2: got %h want 00aa", v); end
    // r1 = 1, then r1 = r1 + 1 on consecutive cycles
    sb.push_back(16'h0001);
    drive(1'b0, 16'd1, 16'h0002, 5'd0, 5'd0, 1'b1, OP_MOV, 1'b1);
    void'(sb.pop_front());
    sb.push_back(16'h0002);
    sb.push_back(16'h0003);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 16'd1, 16'h0002, 5'd2, 5'd0, 1'b1, OP_ADD, 1'b1);
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL b2b_scoreboard %0d: got empty queue want entry", k);
      end else begin
        e = sb.pop_front();
        if (bus_out !== e || bus_valid !== 1'b1) begin failures++; $display("FAIL b2b_bus %0d: got %h/%b want %h/1", k, bus_out, bus_valid, e); end
      end
      peek(4'd1, v);
      checks++;
      if (v !== 16'(k + 2)) begin failures++; $display("FAIL b2b_r1 %0d: got %h want %h", k, v, 16'(k + 2)); end
    end
    // Undefined opcode behaves as NOP
    fl = flags;
    drive(1'b0, 16'h1234, 16'h0002, 5'd2, 5'd0, 1'b1, 8'hFF, 1'b1);
    checks++;
    if (bus_valid !== 1'b0 || bus_out !== 16'h0003 || flags !== fl) begin
      failures++; $display("FAIL undef_op: got %h/%b/%b want 0003/0/%b", bus_out, bus_valid, flags, fl);
    end
    peek(4'd1, v);
    checks++;
    if (v !== 16'h0003) begin failures++; $display("FAIL undef_r1: got %h want 0003", v); end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] v, e;
    logic [15:0] men [3] = '{16'h0002, 16'h0004, 16'h0008};
    logic [4:0]  mc1 [3] = '{5'd1, 5'd1, 5'd2};
    logic [4:0]  mc2 [3] = '{5'd0, 5'd0, 5'd3};
    logic        mic [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] mexp[3] = '{16'd1, 16'd1, 16'd2};
    for (int s = 0; s < 3; s++) begin
      sb.push_back(mexp[s]);
      drive(1'b0, 16'd1, men[s], mc1[s], mc2[s], mic[s], OP_ADD, 1'b1);
      e = sb.pop_front();
      checks++;
      if (bus_out !== e) begin failures++; $display("FAIL mid_bus step%0d: got %h want %h", s + 1, bus_out, e); end
    end
    // Step 4 with reset asserted: the add must not land
    drive(1'b1, 16'd1, 16'h0010, 5'd3, 5'd4, 1'b0, OP_ADD, 1'b1);
    checks++;
    if (bus_valid !== 1'b0 || bus_out !== 16'h0000 || flags !== 5'b00000) begin
      failures++; $display("FAIL mid_reset_state: got %h/%b/%b want 0000/0/00000", bus_out, bus_valid, flags);
    end
    for (int i = 1; i < 6; i++) begin
      peek(4'(i), v);
      checks++;
      if (v !== 16'h0000) begin failures++; $display("FAIL mid_reset_r%0d: got %h want 0000", i, v); end
    end
    drive(1'b0, 16'd0, 16'h0000, 5'd0, 5'd0, 1'b0, OP_NOP, 1'b0);
    checks++;
    if (bus_valid !== 1'b0) begin failures++; $display("FAIL mid_release_valid: got %b want 0", bus_valid); end
  endtask

  initial begin
    test_reset();
    test_fibonacci();
    test_arith_edges();
    test_gating();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_alu_datapath.md
Name: regfile_alu_datapath

Overview:
- Execution datapath driven cycle-by-cycle by the sequencer FSM that runs the Fibonacci program.
- Holds sixteen 16-bit registers (r0..r15), two operand select muxes, an immediate substitute path, an ALU, a result-bus register and a processor status (flags) register.
- Consumes the FSM's control bundle directly (immediate, enable, control1/2, imm_control, opcode, buff_en) and executes one operation per clock.

Parameters:
- WIDTH, 16, datapath and register width.
- NREGS, 16, number of registers; also the width of the one-hot enable.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- immediate  in  16  immediate operand.
- enable  in  16  one-hot (or multi-hot) register write enable; bit n writes rn.
- control1  in  5  A-operand select: code 1..16 selects r(code-1); code 0 or 17..31 gives 0.
- control2  in  5  B-operand select, same coding as control1.
- imm_control  in  1  1: B operand = immediate (control2 ignored).
- opcode  in  8  ALU operation.
- buff_en  in  1  result-bus enable; gates register writeback and bus update.
- bus_out  out  16  registered ALU result of the last executed op.
- bus_valid  out  1  1 for the cycle after a buff_en op that updated bus_out.
- flags  out  5  {C, L, F, Z, N} status register.
- dbg_sel  in  4  debug read select.
- dbg_data  out  16  combinational contents of r[dbg_sel].

Behaviour:
- Reset is synchronous and active-high; one clock, clk. On reset: all registers = 0, bus_out = 0, bus_valid = 0, flags = 0. Reset overrides any op in the same cycle.
- Controls are sampled on the rising edge of clk; the FSM changes them on the falling edge, so they are stable at sampling.
- Operands A and B are read combinationally from the current register contents. Same-cycle read/write returns the OLD value. New values are visible one cycle after the write edge.
- Opcodes: 0x00 NOP; 0x01 AND; 0x02 OR; 0x03 XOR; 0x04 NOT A; 0x05 ADD A+B; 0x06 ADDC A+B+C; 0x07 SUB A-B; 0x08 CMP; 0x09 LSH A<<B[3:0]; 0x0A RSH logical A>>B[3:0]; 0x0B MOV B. All other codes execute as NOP.
- Execute edge when buff_en=1 and op is not NOP/CMP:
  - every rn with enable[n]=1 is loaded with the result; multiple bits set write all selected registers;
  - bus_out <= result; bus_valid <= 1.
- When buff_en=0:
  - no register write, bus_out holds, bus_valid <= 0;
  - flags still update for valid ops, so a compare can be run without writeback.
- NOP (including undefined codes): no writes, flags hold; bus_valid <= 0.
- CMP:
  - never writes registers or bus_out; bus_valid <= 0;
  - Z = (A==B); N = signed A<B; L = unsigned A<B; C and F hold.
- Flag rules for all other ops:
  - Z = (result==0) and N = result[15] for all result-producing ops.
  - C = carry out for ADD/ADDC; C = borrow (A<B unsigned) for SUB.
  - F = signed overflow for ADD/ADDC/SUB.
  - L = unsigned A<B for SUB.
  - Flags not listed for an op hold their value.
- Arithmetic is 17-bit internally; the stored result is truncated to 16 bits (wraps). Shifts fill with zeros; a shift amount of 0 passes A through.
- enable=0 with buff_en=1: bus_out updates, no register changes.
- The sequencer's terminal state repeats the same op every cycle; the datapath re-executes it each cycle (non-idempotent ops re-accumulate; this is intended).

Test Plan:
- Reset behaviour: assert reset for 2 cycles with buff_en=1, enable=0xFFFF, ADD, imm=5 -> all regs 0, flags 0, bus_valid 0.
- Fibonacci program:
  - r1=r0+imm1, then r2=r0+imm1, r3=r1+r2, r4=r2+r3, r5=r3+r4;
  - -> r1..r5 = 1,1,2,3,5; bus_out after each step = 1,1,2,3,5; hold step 5 -> r5 stays 5.
- Arithmetic edges:
  - 0x7FFF+imm1 -> 0x8000, F=1, N=1, C=0;
  - 0xFFFF+imm1 -> 0x0000, C=1, Z=1;
  - SUB 3-5 -> 0xFFFE, C=1, L=1, N=1.
- Gating:
  - buff_en=0 with enable=0x0002, ADD -> r1 unchanged, bus_out holds, flags updated;
  - CMP r1=5 vs imm 5 -> Z=1, no register write.
- Multi-write and hazard:
  - enable=0x0006 with MOV imm 0x00AA -> r1=r2=0x00AA;
  - same-cycle r1=r1+imm1 twice from r1=1 -> 2, then 3 (old-value read each cycle).
- Reset mid-operation: pulse reset during the Fibonacci step-4 cycle -> r4 not written, all regs 0 next cycle, bus_valid 0.
